e203_nice_csr_regfile: RTL and testbench
========================================

# e203_nice_csr_regfile

NICE-side CSR agent that terminates the NICE CSR channel driven by the ALU CSR control stage for CSR indices 0xE00–0xEFF. It provides a small CSR bank of control, status, cycle-count and scratch registers, plus a start/run/done sequencer that back-pressures the channel while an operation is running. The read data path is combinational, so the CSR control stage can complete the read and the write-back in the same handshake cycle.

## Interface
Parameters
- CSR_NUM, default 8 — number of implemented CSRs at offsets 0..CSR_NUM-1; power of 2, range 4..256.
- BUSY_CYC, default 4 — number of cycles spent in RUN per operation; must be ≥1.

Ports
- clk  input  1  — single clock; all state is updated on the rising edge.
- rst  input  1  — reset, asynchronous and active-high; clears all state.
- nice_csr_valid  input  1  — request valid from CSR control.
- nice_csr_ready  output  1  — request accepted; combinational from state only.
- nice_csr_addr  input  32  — CSR index, zero-extended.
- nice_csr_wr  input  1  — 1 = write, 0 = read-only access.
- nice_csr_wdata  input  32  — write data.
- nice_csr_rdata  output  32  — read data; combinational from addr and state.
- nice_busy  output  1  — high in RUN.
- nice_irq  output  1  — DONE status AND CTRL.irq_en, registered.

## Operation
- Handshake: an access completes when nice_csr_valid & nice_csr_ready are both high.
- An address is mapped if addr[31:8] == 0x00000E and offset = addr[7:0] < CSR_NUM.
- Register map:
  - Offset 0, CTRL: bit0 start, write-1 pulse, always reads 0. bit1 irq_en, RW. Other bits read 0.
  - Offset 1, STATUS: bit0 busy, RO. bit1 done, sticky; writing 1 clears it. Other bits read 0.
  - Offset 2, CYCLES: RO. Cycles spent in RUN during the last or current operation.
  - Offsets 3..CSR_NUM-1: scratch, 32-bit RW.
- Unmapped accesses, or writes to RO fields: rdata = 0, writes ignored, ready follows the normal rule.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on an accepted write to CTRL with start=1. On entry: counter = BUSY_CYC-1, CYCLES = 0, done = 0.
  - RUN → DONE when the counter reaches 0. CYCLES increments every RUN cycle, so it holds BUSY_CYC on exit.
  - DONE → RUN on a start write; done clears.
  - DONE → IDLE when done is cleared by a W1C write.
- nice_csr_ready = 0 in RUN; 1 in IDLE and DONE.
- rdata returns the pre-write value. Writes take effect at the clock edge of the handshake.

## Timing
- Reset values:
  - nice_csr_ready = 1, nice_busy = 0, nice_irq = 0.
  - All CSRs = 0; FSM = IDLE.
  - rdata = 0 for any address that reads a reset-zero register.
- Start write at edge T: nice_busy is high from T+1 for BUSY_CYC cycles. done is set at edge T+BUSY_CYC. nice_irq rises one cycle after done when irq_en = 1.
- Simultaneous RUN→DONE done-set and W1C clear: cannot occur, because ready = 0 in RUN.
- A start write in DONE that also sets irq_en: both take effect at the same edge.
- Asynchronous reset asserted mid-RUN: immediate return to IDLE and all outputs at reset values. The in-flight operation is lost.
- No combinational path from nice_csr_valid to nice_csr_ready.

## Configuration
- E203_NICE_CSR_CYCCNT_EN defined: the CYCLES register and its 32-bit counter are implemented as described above.
- Not defined: offset 2 reads 0 and writes are ignored; no counter flops are built. The sequencer still uses its internal BUSY_CYC down-counter.

## Structure
- Shared package e203_nice_csr_pkg contains:
  - Offset constants CTRL_OFS=0, STATUS_OFS=1, CYCLES_OFS=2.
  - Base constant NICE_CSR_BASE = 12'hE00.
  - Enum nice_seq_e {IDLE, RUN, DONE}.
  - CTRL and STATUS bit-position constants.
- One sub-module, e203_nice_csr_seq, holds the FSM and the down-counter. It takes a start pulse and a done-clear pulse, and returns busy and done.
- The top level holds the address decode, the register bank and the read mux.

## Test plan
- Reset: assert rst mid-simulation → ready = 1, busy = 0, irq = 0; a read of 0xE01 returns 0.
- Scratch: write 0xE03 = 0xDEADBEEF, then read 0xE03 → 0xDEADBEEF; the read in the write's own handshake cycle returns 0 (old value).
- Run sequence: write 0xE00 = 0x3 (start and irq_en), BUSY_CYC = 4 → busy high for 4 cycles with ready = 0. Then 0xE01 reads 0x2, 0xE02 reads 4, and irq rises one cycle after done.
- Back-pressure: hold valid during RUN → no handshake until DONE; the access completes in the first DONE cycle.
- W1C clear and restart: write 0xE01 = 0x2 → done = 0, irq falls, FSM in IDLE. A start write from DONE → re-enters RUN and CYCLES restarts from 0.
- Unmapped addresses: read 0xE10 with CSR_NUM = 8 → 0; write 0x0E00_0E04 → ignored, ready = 1. With the macro undefined, 0xE02 reads 0 after a full run.

Source files
------------

// File: rtl/e203_nice_csr_pkg.sv
// Shared constants and types for the NICE-side CSR agent (CSR page 0xE00-0xEFF).
package e203_nice_csr_pkg;

    localparam logic [11:0] NICE_CSR_BASE = 12'hE00;
    // Upper address bits that select the NICE CSR page
    localparam logic [23:0] NICE_CSR_PAGE = 24'(NICE_CSR_BASE >> 8);

    localparam logic [7:0] CTRL_OFS    = 8'd0;
    localparam logic [7:0] STATUS_OFS  = 8'd1;
    localparam logic [7:0] CYCLES_OFS  = 8'd2;
    localparam int         SCRATCH_OFS = 3;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nice_seq_e;

endpackage

// File: rtl/e203_nice_csr_regfile_if.sv
// NICE CSR channel between the ALU CSR control stage (master) and the CSR agent (slave).
interface e203_nice_csr_regfile_if;
    logic        nice_csr_valid;
    logic        nice_csr_ready;
    logic [31:0] nice_csr_addr;
    logic        nice_csr_wr;
    logic [31:0] nice_csr_wdata;
    logic [31:0] nice_csr_rdata;

    modport master (
        output nice_csr_valid, nice_csr_addr, nice_csr_wr, nice_csr_wdata,
        input  nice_csr_ready, nice_csr_rdata
    );

    modport slave (
        input  nice_csr_valid, nice_csr_addr, nice_csr_wr, nice_csr_wdata,
        output nice_csr_ready, nice_csr_rdata
    );
endinterface

// File: rtl/e203_nice_csr_seq.sv
// Start/run/done sequencer: BUSY_CYC cycles in RUN per start, sticky DONE until cleared or restarted.
module e203_nice_csr_seq
    import e203_nice_csr_pkg::*;
#(
    parameter int BUSY_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clr,
    output logic busy,
    output logic done,
    output logic ready
);

    localparam int              CNT_W    = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYC - 1);

    nice_seq_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // start and clr can only arrive while ready, so RUN ignores them
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    cnt_next   = CNT_LOAD;
                end
            end
            RUN: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    cnt_next   = CNT_LOAD;
                end else if (clr) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign ready = (state_reg != RUN);

endmodule

// File: rtl/e203_nice_csr_regfile.sv
// NICE CSR agent: address decode, CTRL/STATUS/CYCLES/scratch bank, combinational read mux.
// Optional cycle counter CSR enabled by defining E203_NICE_CSR_CYCCNT_EN.
module e203_nice_csr_regfile
    import e203_nice_csr_pkg::*;
#(
    parameter int CSR_NUM  = 8,
    parameter int BUSY_CYC = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    e203_nice_csr_regfile_if.slave        csr,
    output logic                          nice_busy,
    output logic                          nice_irq
);

    localparam int OFS_W = $clog2(CSR_NUM);

    logic [7:0]       offset;
    logic [OFS_W-1:0] off_idx;
    logic             mapped;
    logic             seq_ready;
    logic             seq_done;
    logic             wr_hit;
    logic             ctrl_we;
    logic             status_we;
    logic             start_pulse;
    logic             clr_pulse;
    logic             irq_en_reg;
    logic             irq_reg;
    logic [31:0]      cycles_val;
    logic [31:0]      rdata_mux;
    logic [CSR_NUM-1:0] scratch_we;
    logic [31:0]      scratch_reg [CSR_NUM];

    assign offset  = csr.nice_csr_addr[7:0];
    assign off_idx = offset[OFS_W-1:0];
    assign mapped  = (csr.nice_csr_addr[31:8] == NICE_CSR_PAGE) &&
                     ({1'b0, offset} < 9'(CSR_NUM));

    assign wr_hit      = csr.nice_csr_valid & seq_ready & csr.nice_csr_wr & mapped;
    assign ctrl_we     = wr_hit & (offset == CTRL_OFS);
    assign status_we   = wr_hit & (offset == STATUS_OFS);
    assign start_pulse = ctrl_we & csr.nice_csr_wdata[CTRL_START_BIT];
    assign clr_pulse   = status_we & csr.nice_csr_wdata[STATUS_DONE_BIT];

    e203_nice_csr_seq #(
        .BUSY_CYC (BUSY_CYC)
    ) u_seq (
        .clk   (clk),
        .rst   (rst),
        .start (start_pulse),
        .clr   (clr_pulse),
        .busy  (nice_busy),
        .done  (seq_done),
        .ready (seq_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (ctrl_we) begin
                irq_en_reg <= csr.nice_csr_wdata[CTRL_IRQ_EN_BIT];
            end
            irq_reg <= seq_done & irq_en_reg;
        end
    end

    // Offsets below SCRATCH_OFS are control registers; their scratch slots never load
    for (genvar gi = 0; gi < CSR_NUM; gi++) begin : g_scratch_we
        if (gi >= SCRATCH_OFS) begin : g_rw
            assign scratch_we[gi] = wr_hit & (offset == 8'(gi));
        end else begin : g_ctl
            assign scratch_we[gi] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CSR_NUM; i++) begin
                scratch_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CSR_NUM; i++) begin
                if (scratch_we[i]) begin
                    scratch_reg[i] <= csr.nice_csr_wdata;
                end
            end
        end
    end

`ifdef E203_NICE_CSR_CYCCNT_EN
    logic [31:0] cycles_reg;

    // Start is only accepted outside RUN, so clear and count never coincide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_reg <= '0;
        end else if (start_pulse) begin
            cycles_reg <= '0;
        end else if (nice_busy) begin
            cycles_reg <= cycles_reg + 32'd1;
        end
    end

    assign cycles_val = cycles_reg;
`else
    assign cycles_val = '0;
`endif

    always_comb begin
        rdata_mux = '0;
        if (mapped) begin
            unique case (offset)
                CTRL_OFS: begin
                    rdata_mux[CTRL_IRQ_EN_BIT] = irq_en_reg;
                end
                STATUS_OFS: begin
                    rdata_mux[STATUS_BUSY_BIT] = nice_busy;
                    rdata_mux[STATUS_DONE_BIT] = seq_done;
                end
                CYCLES_OFS: begin
                    rdata_mux = cycles_val;
                end
                default: begin
                    rdata_mux = scratch_reg[off_idx];
                end
            endcase
        end
    end

    assign csr.nice_csr_rdata = rdata_mux;
    assign csr.nice_csr_ready = seq_ready;
    assign nice_irq           = irq_reg;

endmodule

// File: tb/tb_e203_nice_csr_regfile.sv
// Self-checking bench: directed vector table, multi-cycle sequences and random traffic vs a behavioural model.
module tb_e203_nice_csr_regfile;

    localparam int CSR_NUM  = 8;
    localparam int BUSY_CYC = 4;
`ifdef E203_NICE_CSR_CYCCNT_EN
    localparam logic [31:0] EXP_CYC = 32'(BUSY_CYC);
`else
    localparam logic [31:0] EXP_CYC = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic irq;

    e203_nice_csr_regfile_if bus();

    e203_nice_csr_regfile #(
        .CSR_NUM  (CSR_NUM),
        .BUSY_CYC (BUSY_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .csr       (bus),
        .nice_busy (busy),
        .nice_irq  (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: remaining run cycles, sticky done, irq_en, cycle count, scratch words
    logic [31:0] m_scr [CSR_NUM];
    logic        m_irq_en;
    logic        m_done;
    logic        m_irq;
    int          m_run_left;
    logic [31:0] m_cycles;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic is_mapped(input logic [31:0] a);
        return (a[31:8] == 24'h00000E) && (int'(a[7:0]) < CSR_NUM);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        int off;
        r = '0;
        off = int'(a[7:0]);
        if (is_mapped(a)) begin
            case (off)
                0: r[1] = m_irq_en;
                1: begin
                    r[0] = (m_run_left > 0);
                    r[1] = m_done;
                end
                2: r = EXP_CYC == 0 ? 32'd0 : m_cycles;
                default: r = m_scr[off];
            endcase
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CSR_NUM; i++) m_scr[i] <= '0;
            m_irq_en   <= 1'b0;
            m_done     <= 1'b0;
            m_irq      <= 1'b0;
            m_run_left <= 0;
            m_cycles   <= '0;
        end else begin
            m_irq <= m_done & m_irq_en;
            if (m_run_left > 0) begin
                m_cycles   <= m_cycles + 32'd1;
                m_run_left <= m_run_left - 1;
                if (m_run_left == 1) m_done <= 1'b1;
            end else if (bus.nice_csr_valid && bus.nice_csr_wr && is_mapped(bus.nice_csr_addr)) begin
                case (int'(bus.nice_csr_addr[7:0]))
                    0: begin
                        m_irq_en <= bus.nice_csr_wdata[1];
                        if (bus.nice_csr_wdata[0]) begin
                            m_run_left <= BUSY_CYC;
                            m_cycles   <= '0;
                            m_done     <= 1'b0;
                        end
                    end
                    1: if (bus.nice_csr_wdata[1]) m_done <= 1'b0;
                    2: ;
                    default: m_scr[int'(bus.nice_csr_addr[7:0])] <= bus.nice_csr_wdata;
                endcase
            end
        end
    end

    // Per-cycle monitor: outputs against the model, one line per accepted transaction
    always @(negedge clk) begin
        chk("ready", 32'(bus.nice_csr_ready), 32'(m_run_left == 0));
        chk("busy", 32'(busy), 32'(m_run_left > 0));
        chk("irq", 32'(irq), 32'(m_irq));
        if (bus.nice_csr_valid) begin
            chk("rdata", bus.nice_csr_rdata, model_read(bus.nice_csr_addr));
            if (bus.nice_csr_ready)
                $display("txn addr=%h wr=%0d wdata=%h rdata=%h", bus.nice_csr_addr,
                         bus.nice_csr_wr, bus.nice_csr_wdata, bus.nice_csr_rdata);
        end
    end

    task automatic do_acc(input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output int waits);
        bus.nice_csr_valid = 1'b1;
        bus.nice_csr_addr  = a;
        bus.nice_csr_wr    = w;
        bus.nice_csr_wdata = d;
        waits = 0;
        @(negedge clk);
        while (!bus.nice_csr_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        chk("handshake", 32'(bus.nice_csr_ready), 32'd1);
        rd = bus.nice_csr_rdata;
        @(posedge clk);
        #1;
        bus.nice_csr_valid = 1'b0;
        bus.nice_csr_wr    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [20];
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;
    int          waits;

    initial begin
        bus.nice_csr_valid = 1'b0;
        bus.nice_csr_addr  = '0;
        bus.nice_csr_wr    = 1'b0;
        bus.nice_csr_wdata = '0;

        tbl[0]  = '{32'h0000_0E01, 1'b0, 32'h0,         32'h0};
        tbl[1]  = '{32'h0000_0E00, 1'b0, 32'h0,         32'h0};
        tbl[2]  = '{32'h0000_0E03, 1'b1, 32'hDEADBEEF,  32'h0};
        tbl[3]  = '{32'h0000_0E03, 1'b0, 32'h0,         32'hDEADBEEF};
        tbl[4]  = '{32'h0000_0E10, 1'b0, 32'h0,         32'h0};
        tbl[5]  = '{32'h0E00_0E04, 1'b1, 32'h12345678,  32'h0};
        tbl[6]  = '{32'h0000_0E04, 1'b0, 32'h0,         32'h0};
        tbl[7]  = '{32'h0000_0E07, 1'b1, 32'h0000A5A5,  32'h0};
        tbl[8]  = '{32'h0000_0E07, 1'b0, 32'h0,         32'h0000A5A5};
        tbl[9]  = '{32'h0000_0E08, 1'b1, 32'hFFFFFFFF,  32'h0};
        tbl[10] = '{32'h0000_0E08, 1'b0, 32'h0,         32'h0};
        tbl[11] = '{32'h0000_0E02, 1'b1, 32'h00000055,  32'h0};
        tbl[12] = '{32'h0000_0E02, 1'b0, 32'h0,         32'h0};
        tbl[13] = '{32'h0000_0E00, 1'b1, 32'h00000002,  32'h0};
        tbl[14] = '{32'h0000_0E00, 1'b0, 32'h0,         32'h2};
        tbl[15] = '{32'h0000_0E00, 1'b1, 32'h00000000,  32'h2};
        tbl[16] = '{32'h0000_0E01, 1'b1, 32'hFFFFFFFF,  32'h0};
        tbl[17] = '{32'h0000_0E01, 1'b0, 32'h0,         32'h0};
        tbl[18] = '{32'h0000_0E00, 1'b1, 32'hFFFFFFFC,  32'h0};
        tbl[19] = '{32'h0000_0E00, 1'b0, 32'h0,         32'h0};

        #2 rst = 1'b1;
        #20 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            do_acc(tbl[i].addr, tbl[i].wr, tbl[i].wdata, rd, waits);
            chk($sformatf("vec%0d", i), rd, tbl[i].exp);
        end

        // Run sequence: start with irq_en, watch busy/ready/irq edge by edge
        do_acc(32'hE00, 1'b1, 32'h3, rd, waits);
        chk("start_rd", rd, 32'h0);
        for (int k = 1; k <= BUSY_CYC; k++) begin
            @(negedge clk);
            chk($sformatf("run_busy%0d", k), 32'(busy), 32'd1);
            chk($sformatf("run_ready%0d", k), 32'(bus.nice_csr_ready), 32'd0);
        end
        @(negedge clk);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        chk("done_irq", 32'(irq), 32'd1);
        @(posedge clk);
        #1;
        do_acc(32'hE01, 1'b0, 32'h0, rd, waits);
        chk("status_done", rd, 32'h2);
        do_acc(32'hE02, 1'b0, 32'h0, rd, waits);
        chk("cycles", rd, EXP_CYC);

        // Back-pressure: restart from DONE, then a held read completes in the first DONE cycle
        do_acc(32'hE00, 1'b1, 32'h3, rd, waits);
        chk("restart_rd", rd, 32'h2);
        do_acc(32'hE02, 1'b0, 32'h0, rd, waits);
        chk("bp_waits", 32'(waits), 32'(BUSY_CYC));
        chk("bp_cycles", rd, EXP_CYC);

        // W1C clear returns to IDLE and drops irq
        do_acc(32'hE01, 1'b1, 32'h2, rd, waits);
        chk("w1c_rd", rd, 32'h2);
        do_acc(32'hE01, 1'b0, 32'h0, rd, waits);
        chk("w1c_status", rd, 32'h0);
        idle(2);
        chk("w1c_irq", 32'(irq), 32'd0);

        // Asynchronous reset mid-RUN
        do_acc(32'hE05, 1'b1, 32'h77, rd, waits);
        do_acc(32'hE00, 1'b1, 32'h3, rd, waits);
        idle(2);
        #3 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.nice_csr_ready), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        do_acc(32'hE05, 1'b0, 32'h0, rd, waits);
        chk("rst_scratch", rd, 32'h0);
        do_acc(32'hE00, 1'b0, 32'h0, rd, waits);
        chk("rst_ctrl", rd, 32'h0);

        // Asynchronous reset with irq asserted in DONE
        do_acc(32'hE00, 1'b1, 32'h3, rd, waits);
        idle(BUSY_CYC + 2);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        do_acc(32'hE01, 1'b0, 32'h0, rd, waits);
        chk("rst_status", rd, 32'h0);

        // Random traffic; the monitor checks every cycle against the model
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'h0E00_0E00 | 32'($urandom_range(0, 15));
                1:       a = $urandom;
                default: a = 32'hE00 + 32'($urandom_range(0, 9));
            endcase
            d = $urandom;
            if (a == 32'hE00 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
            bus.nice_csr_valid = ($urandom_range(0, 3) != 0);
            bus.nice_csr_wr    = $urandom_range(0, 1) == 1;
            bus.nice_csr_addr  = a;
            bus.nice_csr_wdata = d;
            @(posedge clk);
            #1;
        end
        bus.nice_csr_valid = 1'b0;
        bus.nice_csr_wr    = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
